// File: rtl/sram_serial_io_ctrl_pkg.sv
// Shared widths, host command encodings and FSM states for the serial SRAM bridge.
package sram_serial_io_ctrl_pkg;

    localparam int unsigned MEMORY_DATA_WIDTH = 8;
    localparam int unsigned MEMORY_ADDR_WIDTH = 9;
    localparam int unsigned REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
    localparam int unsigned CNT_WIDTH         = 5;

    typedef enum logic [1:0] {
        CTRL_SHIFT = 2'b00,
        CTRL_READ  = 2'b01,
        CTRL_NOP   = 2'b10,
        CTRL_WRITE = 2'b11
    } ctrl_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_MEM_ACC,
        S_MEM_CAP,
        S_DONE
    } state_e;

endpackage

// File: rtl/sram_serial_io_ctrl_shreg.sv
// 17-bit {address, data} register: LSB-first serial shift in, parallel capture of SRAM read data.
module sram_io_shreg
    import sram_serial_io_ctrl_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         shift_en_i,
    input  logic                         cap_en_i,
    input  logic                         si_i,
    input  logic [MEMORY_DATA_WIDTH-1:0] cap_data_i,
    output logic [REG_BITS_WIDTH-1:0]    bits_o
);

    logic [REG_BITS_WIDTH-1:0] bits_q;
    logic [REG_BITS_WIDTH-1:0] bits_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    // Capture only replaces the data byte; the address field is kept for the next access.
    always_comb begin
        bits_d = bits_q;
        if (shift_en_i) begin
            bits_d = {si_i, bits_q[REG_BITS_WIDTH-1:1]};
        end else if (cap_en_i) begin
            bits_d[MEMORY_DATA_WIDTH-1:0] = cap_data_i;
        end
    end

    assign bits_o = bits_q;

endmodule

// File: rtl/sram_serial_io_ctrl.sv
// Serial host to single-port 512x8 SRAM bridge: shift in {addr, data}, then write, read or no-op.
module sram_serial_io_ctrl
    import sram_serial_io_ctrl_pkg::*;
(
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BGN,
    input  logic                         SI,
    input  logic                         LOAD_N,
    input  logic [1:0]                   CTRL,
    input  logic [MEMORY_DATA_WIDTH-1:0] PI,
    output logic                         RDY,
    output logic                         D_WE,
    output logic                         CEN,
    output logic                         SO,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic [MEMORY_DATA_WIDTH-1:0] PO
);

    localparam logic [CNT_WIDTH-1:0] SHIFT_LAST = CNT_WIDTH'(REG_BITS_WIDTH - 1);

    state_e                    state_q;
    state_e                    state_d;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [CNT_WIDTH-1:0]      cnt_d;
    logic                      shift_en;
    logic                      cap_en;
    logic [REG_BITS_WIDTH-1:0] reg_bits;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        cap_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!LOAD_N) state_d = S_WAIT;
            end
            S_WAIT: begin
                unique case (ctrl_e'(CTRL))
                    CTRL_SHIFT: begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                    end
                    CTRL_READ, CTRL_WRITE: state_d = S_MEM_ACC;
                    default:               state_d = S_DONE;
                endcase
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == SHIFT_LAST) state_d = S_DONE;
            end
            S_MEM_ACC: begin
                state_d = (ctrl_e'(CTRL) == CTRL_WRITE) ? S_DONE : S_MEM_CAP;
            end
            S_MEM_CAP: begin
                cap_en  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        // Dropping BGN aborts from any state and leaves the register untouched.
        if (!BGN) begin
            state_d  = S_IDLE;
            cnt_d    = cnt_q;
            shift_en = 1'b0;
            cap_en   = 1'b0;
        end
    end

    sram_io_shreg u_shreg (
        .clk_i      (CLK),
        .rst_i      (RST),
        .shift_en_i (shift_en),
        .cap_en_i   (cap_en),
        .si_i       (SI),
        .cap_data_i (PI),
        .bits_o     (reg_bits)
    );

    assign RDY  = (state_q == S_DONE);
    assign CEN  = !(state_q == S_MEM_ACC);
    assign D_WE = !((state_q == S_MEM_ACC) && (ctrl_e'(CTRL) == CTRL_WRITE));
    assign SO   = reg_bits[0];
    assign A    = reg_bits[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
    assign PO   = reg_bits[MEMORY_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sram_serial_io_ctrl.sv
// Randomized bench for sram_serial_io_ctrl against an operation-level model and a behavioural 512x8 SRAM.
module tb_sram_serial_io_ctrl;
    import sram_serial_io_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       bgn;
    logic       si;
    logic       load_n;
    logic [1:0] ctrl;
    logic [7:0] pi_q;
    logic       rdy;
    logic       d_we;
    logic       cen;
    logic       so;
    logic [8:0] a;
    logic [7:0] po;

    int n_cmp = 0;
    int n_err = 0;
    int cen_total = 0;
    int we_total = 0;

    logic [7:0]  sram    [512];
    logic [7:0]  ref_mem [512];
    logic [16:0] ref_bits;

    always #5 clk = ~clk;

    sram_serial_io_ctrl dut (
        .CLK    (clk),
        .RST    (rst),
        .BGN    (bgn),
        .SI     (si),
        .LOAD_N (load_n),
        .CTRL   (ctrl),
        .PI     (pi_q),
        .RDY    (rdy),
        .D_WE   (d_we),
        .CEN    (cen),
        .SO     (so),
        .A      (a),
        .PO     (po)
    );

    // Behavioural SRAM macro plus access counters.
    always @(posedge clk) begin
        if (!cen) begin
            cen_total <= cen_total + 1;
            if (!d_we) begin
                sram[a]  <= po;
                we_total <= we_total + 1;
            end
            pi_q <= sram[a];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_latency(input logic [1:0] c);
        case (c)
            CTRL_SHIFT: return 19;
            CTRL_WRITE: return 3;
            CTRL_READ:  return 4;
            default:    return 2;
        endcase
    endfunction

    // One complete host transaction, checked against the operation-level model.
    task automatic do_op(input logic [1:0] c, input logic [16:0] word);
        int          edges;
        int          idx;
        int          c0;
        int          w0;
        logic [16:0] exp_bits;
        logic [8:0]  addr;
        c0       = cen_total;
        w0       = we_total;
        exp_bits = ref_bits;
        addr     = ref_bits[16:8];
        case (c)
            CTRL_SHIFT: exp_bits = word;
            CTRL_WRITE: ref_mem[addr] = ref_bits[7:0];
            CTRL_READ:  exp_bits[7:0] = ref_mem[addr];
            default: ;
        endcase
        bgn    = 1'b1;
        ctrl   = c;
        load_n = 1'b0;
        si     = 1'b0;
        edges  = 0;
        while (!rdy && edges < 40) begin
            tick();
            edges++;
            load_n = 1'b1;
            idx    = (edges < 2) ? 0 : edges - 2;
            if (idx < 17) si = word[idx];
        end
        check_eq("latency", 32'(edges), 32'(op_latency(c)));
        check_eq("rdy_done", 32'(rdy), 32'd1);
        check_eq("reg_bits", 32'({a, po}), 32'(exp_bits));
        check_eq("so", 32'(so), 32'(exp_bits[0]));
        check_eq("cen_cycles", 32'(cen_total - c0),
                 32'((c == CTRL_READ || c == CTRL_WRITE) ? 1 : 0));
        check_eq("we_cycles", 32'(we_total - w0), 32'((c == CTRL_WRITE) ? 1 : 0));
        if (c == CTRL_WRITE) check_eq("sram_word", 32'(sram[addr]), 32'(ref_mem[addr]));
        tick();
        check_eq("rdy_hold", 32'(rdy), 32'd1);
        bgn = 1'b0;
        tick();
        check_eq("rdy_drop", 32'(rdy), 32'd0);
        ref_bits = exp_bits;
    endtask

    task automatic write_byte(input logic [8:0] addr, input logic [7:0] data);
        do_op(CTRL_SHIFT, {addr, data});
        do_op(CTRL_WRITE, 17'd0);
    endtask

    task automatic read_byte(input logic [8:0] addr);
        do_op(CTRL_SHIFT, {addr, 8'($urandom)});
        do_op(CTRL_READ, 17'd0);
    endtask

    initial begin
        logic [16:0] word;
        logic [8:0]  addr;
        int          c0;
        int          sel;

        rst      = 1'b1;
        bgn      = 1'b0;
        si       = 1'b0;
        load_n   = 1'b1;
        ctrl     = CTRL_NOP;
        ref_bits = '0;
        repeat (3) tick();
        check_eq("rst_rdy", 32'(rdy), 32'd0);
        check_eq("rst_cen", 32'(cen), 32'd1);
        check_eq("rst_dwe", 32'(d_we), 32'd1);
        check_eq("rst_a", 32'(a), 32'd0);
        check_eq("rst_po", 32'(po), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        check_eq("idle_rdy", 32'(rdy), 32'd0);

        // Directed shift / write / read of 0x04 at 0x020, then a no-op.
        do_op(CTRL_SHIFT, {9'h020, 8'h04});
        do_op(CTRL_WRITE, 17'd0);
        do_op(CTRL_SHIFT, {9'h020, 8'h00});
        do_op(CTRL_READ, 17'd0);
        check_eq("read_020", 32'(po), 32'h04);
        do_op(CTRL_NOP, 17'd0);

        // Program load and readback.
        for (int i = 0; i < 14; i++) write_byte(9'(9'h020 + i), 8'($urandom));
        write_byte(9'h000, 8'hAB);
        write_byte(9'h003, 8'h3C);
        for (int i = 0; i < 14; i++) read_byte(9'(9'h020 + i));
        read_byte(9'h000);
        check_eq("read_000", 32'(po), 32'hAB);
        read_byte(9'h003);
        check_eq("read_003", 32'(po), 32'h3C);

        // Random mixed traffic over a small pre-written window.
        for (int i = 0; i < 8; i++) write_byte(9'(9'h040 + i), 8'($urandom));
        for (int i = 0; i < 30; i++) begin
            addr = 9'(9'h040 + $urandom_range(0, 7));
            sel  = $urandom_range(0, 4);
            if (sel < 2) write_byte(addr, 8'($urandom));
            else if (sel < 4) read_byte(addr);
            else do_op(CTRL_NOP, 17'd0);
        end

        // Abort a shift after 8 bits: register holds the partial shift, no access, no RDY.
        word   = 17'($urandom);
        c0     = cen_total;
        bgn    = 1'b1;
        ctrl   = CTRL_SHIFT;
        load_n = 1'b0;
        tick();
        load_n = 1'b1;
        si     = word[0];
        tick();
        for (int k = 0; k < 8; k++) begin
            si = word[k];
            tick();
            ref_bits = {word[k], ref_bits[16:1]};
        end
        bgn = 1'b0;
        si  = word[8];
        tick();
        check_eq("abort_bits", 32'({a, po}), 32'(ref_bits));
        repeat (4) tick();
        check_eq("abort_rdy", 32'(rdy), 32'd0);
        check_eq("abort_cen", 32'(cen_total - c0), 32'd0);
        check_eq("abort_bits_hold", 32'({a, po}), 32'(ref_bits));

        // Reset asserted while the write strobe is active.
        do_op(CTRL_SHIFT, {9'h041, 8'h5A});
        bgn    = 1'b1;
        ctrl   = CTRL_WRITE;
        load_n = 1'b0;
        tick();
        load_n = 1'b1;
        tick();
        check_eq("acc_cen", 32'(cen), 32'd0);
        check_eq("acc_dwe", 32'(d_we), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("rstacc_cen", 32'(cen), 32'd1);
        check_eq("rstacc_dwe", 32'(d_we), 32'd1);
        check_eq("rstacc_bits", 32'({a, po}), 32'd0);
        check_eq("rstacc_rdy", 32'(rdy), 32'd0);
        tick();
        check_eq("rstacc_sram", 32'(sram[9'h041]), 32'(ref_mem[9'h041]));
        bgn      = 1'b0;
        rst      = 1'b0;
        ref_bits = '0;
        tick();
        read_byte(9'h041);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
